// File: rtl/write_back_unit.sv
// Write-back stage: selects ALU/MEM/LINK result, formats load data (byte/half
// lane extraction with sign/zero extension) and stalls upstream while a load
// is waiting for its memory data, with an optional timeout abort.
module write_back_unit #(
  parameter  int unsigned DATA_WIDTH     = 32,
  parameter  int unsigned REG_ADDR_WIDTH = 5,
  parameter  int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned OFFS_W         = $clog2(DATA_WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic [1:0]                wb_sel_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic [DATA_WIDTH-1:0]     link_data_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic                      mem_data_valid_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_sign_in,
  input  logic [OFFS_W-1:0]         mem_offset_in,
  output logic                      stall_out,
  output logic                      reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
  output logic [DATA_WIDTH-1:0]     reg_wr_data_out,
  output logic                      mem_timeout_out
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] SEL_MEM   = 2'b01;
  localparam logic [1:0] SEL_LINK  = 2'b10;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      cap_en, cap_en_nxt;
  logic [REG_ADDR_WIDTH-1:0] cap_addr, cap_addr_nxt;
  logic [1:0]                cap_size, cap_size_nxt;
  logic                      cap_sign, cap_sign_nxt;
  logic [OFFS_W-1:0]         cap_off, cap_off_nxt;
  logic                      wr_en_nxt;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_nxt;
  logic [DATA_WIDTH-1:0]     wr_data_nxt;
  logic                      timeout_nxt;
  logic [DATA_WIDTH-1:0]     sel_data_c;
  logic                      load_late_c;

  // Big-endian lane extraction: offset 0 is the most significant byte.
  function automatic logic [DATA_WIDTH-1:0] format_load(
    input logic [DATA_WIDTH-1:0] raw,
    input logic [1:0]            size,
    input logic                  sign,
    input logic [OFFS_W-1:0]     off
  );
    int unsigned lane;
    int unsigned bsh;
    int unsigned hsh;
    logic [7:0]  b;
    logic [15:0] h;
    lane = 32'(off);
    bsh  = DATA_WIDTH - 8 - 8 * lane;
    hsh  = DATA_WIDTH - 16 - 16 * (lane >> 1);
    b    = 8'(raw >> bsh);
    h    = 16'(raw >> hsh);
    case (size)
      SIZE_BYTE: format_load = {{(DATA_WIDTH - 8){sign & b[7]}}, b};
      SIZE_HALF: format_load = {{(DATA_WIDTH - 16){sign & h[15]}}, h};
      default:   format_load = raw;
    endcase
  endfunction

  // Result mux for an instruction completing directly from IDLE.
  always_comb begin
    sel_data_c = alu_data_in;
    case (wb_sel_in)
      SEL_MEM:  sel_data_c = format_load(mem_data_in, mem_size_in, mem_sign_in, mem_offset_in);
      SEL_LINK: sel_data_c = link_data_in;
      default:  sel_data_c = alu_data_in;
    endcase
  end

  assign load_late_c = (wb_sel_in == SEL_MEM) && !mem_data_valid_in;

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      cap_en          <= 1'b0;
      cap_addr        <= '0;
      cap_size        <= '0;
      cap_sign        <= 1'b0;
      cap_off         <= '0;
      reg_wr_en_out   <= 1'b0;
      reg_wr_addr_out <= '0;
      reg_wr_data_out <= '0;
      mem_timeout_out <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      cap_en          <= cap_en_nxt;
      cap_addr        <= cap_addr_nxt;
      cap_size        <= cap_size_nxt;
      cap_sign        <= cap_sign_nxt;
      cap_off         <= cap_off_nxt;
      reg_wr_en_out   <= wr_en_nxt;
      reg_wr_addr_out <= wr_addr_nxt;
      reg_wr_data_out <= wr_data_nxt;
      mem_timeout_out <= timeout_nxt;
    end
  end

  // Next-state, capture and write-back decision.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cap_en_nxt   = cap_en;
    cap_addr_nxt = cap_addr;
    cap_size_nxt = cap_size;
    cap_sign_nxt = cap_sign;
    cap_off_nxt  = cap_off;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = reg_wr_addr_out;
    wr_data_nxt  = reg_wr_data_out;
    timeout_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (valid_in) begin
          if (load_late_c) begin
            cap_en_nxt   = reg_wr_en_in && (reg_wr_addr_in != '0);
            cap_addr_nxt = reg_wr_addr_in;
            cap_size_nxt = mem_size_in;
            cap_sign_nxt = mem_sign_in;
            cap_off_nxt  = mem_offset_in;
            cnt_nxt      = '0;
            state_nxt    = WAIT_MEM;
          end else begin
            wr_en_nxt   = reg_wr_en_in && (reg_wr_addr_in != '0);
            wr_addr_nxt = reg_wr_addr_in;
            wr_data_nxt = sel_data_c;
          end
        end
      end

      WAIT_MEM: begin
        if (mem_data_valid_in) begin
          // Arriving data beats a simultaneous timeout.
          wr_en_nxt   = cap_en;
          wr_addr_nxt = cap_addr;
          wr_data_nxt = format_load(mem_data_in, cap_size, cap_sign, cap_off);
          state_nxt   = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Stall is a direct decode of the state flop.
  assign stall_out = (state == WAIT_MEM);

endmodule

// File: tb/tb_write_back_unit.sv
// Self-checking bench for write_back_unit: expected writes are queued when an
// instruction is driven and compared when the write-back output appears.
module tb_write_back_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 2;
  localparam int unsigned TO = 4;

  localparam logic [1:0] S_ALU  = 2'b00;
  localparam logic [1:0] S_MEM  = 2'b01;
  localparam logic [1:0] S_LINK = 2'b10;
  localparam logic [1:0] S_ALT  = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic          reg_wr_en_in;
  logic [AW-1:0] reg_wr_addr_in;
  logic [1:0]    wb_sel_in;
  logic [DW-1:0] alu_data_in;
  logic [DW-1:0] link_data_in;
  logic [DW-1:0] mem_data_in;
  logic          mem_data_valid_in;
  logic [1:0]    mem_size_in;
  logic          mem_sign_in;
  logic [OW-1:0] mem_offset_in;
  logic          stall_out;
  logic          reg_wr_en_out;
  logic [AW-1:0] reg_wr_addr_out;
  logic [DW-1:0] reg_wr_data_out;
  logic          mem_timeout_out;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sbq[$];

  write_back_unit #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_in         (valid_in),
    .reg_wr_en_in     (reg_wr_en_in),
    .reg_wr_addr_in   (reg_wr_addr_in),
    .wb_sel_in        (wb_sel_in),
    .alu_data_in      (alu_data_in),
    .link_data_in     (link_data_in),
    .mem_data_in      (mem_data_in),
    .mem_data_valid_in(mem_data_valid_in),
    .mem_size_in      (mem_size_in),
    .mem_sign_in      (mem_sign_in),
    .mem_offset_in    (mem_offset_in),
    .stall_out        (stall_out),
    .reg_wr_en_out    (reg_wr_en_out),
    .reg_wr_addr_out  (reg_wr_addr_out),
    .reg_wr_data_out  (reg_wr_data_out),
    .mem_timeout_out  (mem_timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic en, input logic [AW-1:0] a,
                       input logic [1:0] sel, input logic [DW-1:0] alu,
                       input logic [DW-1:0] link, input logic [DW-1:0] mem,
                       input logic mv, input logic [1:0] sz, input logic sg,
                       input logic [OW-1:0] off);
    valid_in          = v;
    reg_wr_en_in      = en;
    reg_wr_addr_in    = a;
    wb_sel_in         = sel;
    alu_data_in       = alu;
    link_data_in      = link;
    mem_data_in       = mem;
    mem_data_valid_in = mv;
    mem_size_in       = sz;
    mem_sign_in       = sg;
    mem_offset_in     = off;
  endtask

  task automatic idle_in();
    valid_in          = 1'b0;
    mem_data_valid_in = 1'b0;
  endtask

  task automatic push(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.en   = en;
    e.addr = a;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic expect_wr(input string tag);
    wr_t e;
    if (sbq.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sbq.pop_front();
      check_eq({tag, "_en"}, 64'(reg_wr_en_out), 64'(e.en));
      if (e.en) begin
        check_eq({tag, "_addr"}, 64'(reg_wr_addr_out), 64'(e.addr));
        check_eq({tag, "_data"}, 64'(reg_wr_data_out), 64'(e.data));
      end
    end
  endtask

  // Non-stalling instruction: one cycle to the registered write.
  task automatic issue(input string tag, input logic en, input logic [AW-1:0] a,
                       input logic [1:0] sel, input logic [DW-1:0] alu,
                       input logic [DW-1:0] link, input logic [DW-1:0] mem,
                       input logic [1:0] sz, input logic sg, input logic [OW-1:0] off,
                       input logic exp_en, input logic [DW-1:0] exp_data);
    drive(1'b1, en, a, sel, alu, link, mem, 1'b1, sz, sg, off);
    push(exp_en, a, exp_data);
    tick();
    expect_wr(tag);
    check_eq({tag, "_stall"}, 64'(stall_out), 64'd0);
    idle_in();
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_en"},      64'(reg_wr_en_out),   64'd0);
    check_eq({tag, "_stall"},   64'(stall_out),       64'd0);
    check_eq({tag, "_timeout"}, 64'(mem_timeout_out), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, S_ALU, '0, '0, '0, 1'b0, 2'b00, 1'b0, '0);
    tick();
    tick();
    check_quiet("reset");
    check_eq("reset_addr", 64'(reg_wr_addr_out), 64'd0);
    check_eq("reset_data", 64'(reg_wr_data_out), 64'd0);
    rst_n = 1'b1;
    tick();

    // Plain ALU / LINK / r0 suppression.
    issue("alu", 1'b1, 5'd3, S_ALU, 32'h0000_1234, 32'h0, 32'h0, 2'b00, 1'b0, '0, 1'b1, 32'h0000_1234);
    tick();
    check_quiet("alu_bubble");
    issue("r0", 1'b1, 5'd0, S_ALU, 32'h5555_AAAA, 32'h0, 32'h0, 2'b00, 1'b0, '0, 1'b0, 32'h0);
    issue("en_off", 1'b0, 5'd9, S_ALU, 32'h1111_2222, 32'h0, 32'h0, 2'b00, 1'b0, '0, 1'b0, 32'h0);
    issue("link", 1'b1, 5'd31, S_LINK, 32'h1, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
    issue("sel11", 1'b1, 5'd2, S_ALT, 32'h0BAD_F00D, 32'h7, 32'h9, 2'b00, 1'b0, '0, 1'b1, 32'h0BAD_F00D);

    // Loads with data on arrival, back to back.
    issue("byte_s", 1'b1, 5'd10, S_MEM, 32'h0, 32'h0, 32'h12F4_5678, 2'b00, 1'b1, 2'd1, 1'b1, 32'hFFFF_FFF4);
    issue("byte_u", 1'b1, 5'd11, S_MEM, 32'h0, 32'h0, 32'h12F4_5678, 2'b00, 1'b0, 2'd1, 1'b1, 32'h0000_00F4);
    issue("byte_o3", 1'b1, 5'd12, S_MEM, 32'h0, 32'h0, 32'h12F4_5688, 2'b00, 1'b1, 2'd3, 1'b1, 32'hFFFF_FF88);
    issue("half_o2", 1'b1, 5'd13, S_MEM, 32'h0, 32'h0, 32'h8001_ABCD, 2'b01, 1'b1, 2'd2, 1'b1, 32'hFFFF_ABCD);
    issue("half_o0", 1'b1, 5'd14, S_MEM, 32'h0, 32'h0, 32'h8001_ABCD, 2'b01, 1'b1, 2'd0, 1'b1, 32'hFFFF_8001);
    issue("half_o1", 1'b1, 5'd15, S_MEM, 32'h0, 32'h0, 32'h8001_ABCD, 2'b01, 1'b0, 2'd1, 1'b1, 32'h0000_8001);
    issue("word", 1'b1, 5'd16, S_MEM, 32'h0, 32'h0, 32'h8001_ABCD, 2'b10, 1'b1, 2'd3, 1'b1, 32'h8001_ABCD);

    // Late load with a held ALU instruction behind it.
    drive(1'b1, 1'b1, 5'd4, S_MEM, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 2'd0);
    push(1'b1, 5'd4, 32'h0000_007F);
    tick();
    check_eq("late_c1_stall", 64'(stall_out), 64'd1);
    check_eq("late_c1_en", 64'(reg_wr_en_out), 64'd0);
    drive(1'b1, 1'b1, 5'd6, S_ALU, 32'h0000_CAFE, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0, 2'd3);
    push(1'b1, 5'd6, 32'h0000_CAFE);
    tick();
    check_eq("late_c2_stall", 64'(stall_out), 64'd1);
    check_eq("late_c2_en", 64'(reg_wr_en_out), 64'd0);
    tick();
    check_eq("late_c3_stall", 64'(stall_out), 64'd1);
    check_eq("late_c3_en", 64'(reg_wr_en_out), 64'd0);
    mem_data_in       = 32'h7F00_0000;
    mem_data_valid_in = 1'b1;
    tick();
    expect_wr("late_load");
    check_eq("late_done_stall", 64'(stall_out), 64'd0);
    mem_data_valid_in = 1'b0;
    tick();
    expect_wr("held_alu");
    idle_in();
    tick();
    check_quiet("after_held");

    // Timeout: data never arrives.
    drive(1'b1, 1'b1, 5'd7, S_MEM, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 2'd0);
    tick();
    idle_in();
    for (int i = 0; i < int'(TO); i++) begin
      check_eq($sformatf("to_c%0d_stall", i), 64'(stall_out), 64'd1);
      check_eq($sformatf("to_c%0d_pulse", i), 64'(mem_timeout_out), 64'd0);
      check_eq($sformatf("to_c%0d_en", i), 64'(reg_wr_en_out), 64'd0);
      tick();
    end
    check_eq("to_pulse", 64'(mem_timeout_out), 64'd1);
    check_eq("to_stall", 64'(stall_out), 64'd0);
    check_eq("to_en", 64'(reg_wr_en_out), 64'd0);
    tick();
    check_quiet("to_after");

    // Reset in the middle of a wait aborts the load.
    drive(1'b1, 1'b1, 5'd8, S_MEM, 32'h0, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0, 2'd0);
    tick();
    idle_in();
    tick();
    check_eq("rstwait_stall", 64'(stall_out), 64'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("rstwait_async");
    check_eq("rstwait_data", 64'(reg_wr_data_out), 64'd0);
    #2;
    rst_n = 1'b1;
    mem_data_in       = 32'hA5A5_A5A5;
    mem_data_valid_in = 1'b1;
    tick();
    check_quiet("rstwait_nowrite");
    idle_in();

    // Post-reset sanity write.
    issue("post_rst", 1'b1, 5'd20, S_ALU, 32'h0000_0042, 32'h0, 32'h0, 2'b00, 1'b0, '0, 1'b1, 32'h0000_0042);
    check_eq("sb_drained", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
